// File: rtl/fast_square_pkg.sv
// Shared types and constants for the fast-square sweep sequencer.
package fast_square_pkg;

    localparam int unsigned TICK_W   = 16;
    localparam int unsigned SETTLE_W = 8;
    localparam int unsigned STEPS_W  = 6;
    localparam int unsigned ADDR_W   = 7;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CFG_W    = 31;

    // serial_data field positions
    localparam int unsigned RECORD_LSB = 0;
    localparam int unsigned RECORD_MSB = 15;
    localparam int unsigned SETTLE_LSB = 16;
    localparam int unsigned SETTLE_MSB = 23;
    localparam int unsigned STEPS_LSB  = 24;
    localparam int unsigned STEPS_MSB  = 29;
    localparam int unsigned CONT_BIT   = 31;

    localparam logic [ADDR_W-1:0] DEF_CFG_ADDR = 7'd80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SETTLE,
        ST_RECORD,
        ST_NEXT
    } state_t;

    // Packed sweep configuration: bit 30 of serial_data is dropped
    typedef struct packed {
        logic                continuous;
        logic [STEPS_W-1:0]  steps;
        logic [SETTLE_W-1:0] settle;
        logic [TICK_W-1:0]   record;
    } cfg_t;

    // Countdown preload: a phase of N ticks loads N-1, and 0 behaves as 1
    function automatic logic [TICK_W-1:0] ticks_to_load(input logic [TICK_W-1:0] ticks);
        return (ticks == '0) ? '0 : TICK_W'(ticks - TICK_W'(1));
    endfunction

endpackage

// File: rtl/fs_tick_timer.sv
// 16-bit load/countdown timer; zero is high once the count reaches 0.
module fs_tick_timer
    import fast_square_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [TICK_W-1:0] value,
    output logic              zero
);

    logic [TICK_W-1:0] count;

    // Load takes priority; otherwise count down and hold at zero
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= TICK_W'(count - TICK_W'(1));
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/setting_reg.sv
// Settings-bus register: captures data when its address is strobed.
module setting_reg #(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [6:0]        MY_ADDR  = 7'd0,
    parameter logic [WIDTH-1:0]  AT_RESET = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             strobe,
    input  logic [6:0]       addr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    // Output register, loaded with the reset default
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out <= AT_RESET;
        end else if (strobe && (addr == MY_ADDR)) begin
            data_out <= data_in;
        end
    end

endmodule

// File: rtl/fast_square_sweep_sched.sv
// Fast-square sweep sequencer: steps the synthesizer and strobes the combiners.
module fast_square_sweep_sched
    import fast_square_pkg::*;
#(
    parameter logic [ADDR_W-1:0]   CFG_ADDR   = DEF_CFG_ADDR,
    parameter logic [TICK_W-1:0]   DEF_RECORD = 16'd35000,
    parameter logic [SETTLE_W-1:0] DEF_SETTLE = 8'd64,
    parameter logic [STEPS_W-1:0]  DEF_STEPS  = 6'd32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               trigger,
    input  logic               serial_strobe,
    input  logic [ADDR_W-1:0]  serial_addr,
    input  logic [DATA_W-1:0]  serial_data,
    output logic               rx_reset,
    output logic               rx_record,
    output logic               rx_next,
    output logic               freq_step_out,
    output logic [STEPS_W-1:0] step_index,
    output logic               busy,
    output logic               sweep_done
);

    localparam cfg_t CFG_DEFAULT = '{
        continuous: 1'b0,
        steps:      DEF_STEPS,
        settle:     DEF_SETTLE,
        record:     DEF_RECORD
    };

    state_t            state;
    state_t            next_state;
    logic [CFG_W-1:0]  cfg_in;
    logic [CFG_W-1:0]  shadow_bits;
    cfg_t              shadow;
    cfg_t              work;
    logic              trigger_q;
    logic              trigger_hold;
    logic              trigger_rise;
    logic              last_step;
    logic              timer_load;
    logic [TICK_W-1:0] timer_value;
    logic              timer_zero;
    logic              unused_cfg_bit;

    assign cfg_in         = {serial_data[CONT_BIT], serial_data[STEPS_MSB:RECORD_LSB]};
    assign unused_cfg_bit = serial_data[30];
    assign shadow         = cfg_t'(shadow_bits);
    assign trigger_rise   = trigger && !trigger_q && !trigger_hold;
    assign last_step      = (step_index == STEPS_W'(work.steps - STEPS_W'(1)));

    setting_reg #(
        .WIDTH    (CFG_W),
        .MY_ADDR  (CFG_ADDR),
        .AT_RESET (CFG_DEFAULT)
    ) u_cfg_reg (
        .clock    (clock),
        .reset    (reset),
        .strobe   (serial_strobe),
        .addr     (serial_addr),
        .data_in  (cfg_in),
        .data_out (shadow_bits)
    );

    fs_tick_timer u_timer (
        .clock (clock),
        .reset (reset),
        .load  (timer_load),
        .value (timer_value),
        .zero  (timer_zero)
    );

    // Trigger edge detect; a level held through reset must fall before it can fire again
    always_ff @(posedge clock) begin
        if (reset) begin
            trigger_q    <= 1'b0;
            trigger_hold <= trigger;
        end else begin
            trigger_q <= trigger;
            if (!trigger) begin
                trigger_hold <= 1'b0;
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and timer preload on entry to a timed phase
    always_comb begin
        next_state  = state;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            ST_IDLE: begin
                if (trigger_rise && (shadow.steps != '0)) begin
                    next_state = ST_START;
                end
            end
            ST_START: begin
                next_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (timer_zero) begin
                    next_state = ST_RECORD;
                end
            end
            ST_RECORD: begin
                if (timer_zero) begin
                    next_state = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (!last_step) begin
                    next_state = ST_SETTLE;
                end else if (work.continuous && (shadow.steps != '0)) begin
                    next_state = ST_START;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        if ((next_state == ST_SETTLE) && (state != ST_SETTLE)) begin
            timer_load  = 1'b1;
            timer_value = ticks_to_load(TICK_W'(work.settle));
        end else if ((next_state == ST_RECORD) && (state != ST_RECORD)) begin
            timer_load  = 1'b1;
            timer_value = ticks_to_load(work.record);
        end
    end

    // Registered strobes, working config capture and step index
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_reset      <= 1'b0;
            rx_record     <= 1'b0;
            rx_next       <= 1'b0;
            freq_step_out <= 1'b0;
            busy          <= 1'b0;
            sweep_done    <= 1'b0;
            step_index    <= '0;
            work          <= '0;
        end else begin
            rx_reset      <= (next_state == ST_START);
            rx_record     <= (next_state == ST_RECORD);
            rx_next       <= (next_state == ST_NEXT);
            freq_step_out <= (next_state == ST_NEXT);
            busy          <= (next_state != ST_IDLE);
            sweep_done    <= (next_state == ST_NEXT) && last_step;
            if (next_state == ST_START) begin
                work       <= shadow;
                step_index <= '0;
            end else if (state == ST_NEXT) begin
                step_index <= last_step ? '0 : STEPS_W'(step_index + STEPS_W'(1));
            end
        end
    end

endmodule

// File: tb/tb_fast_square_sweep_sched.sv
// Scoreboard bench for fast_square_sweep_sched: expected strobe events are
// queued as stimulus is issued and a negedge monitor matches them.
module tb_fast_square_sweep_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic        trigger;
    logic        serial_strobe;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        rx_reset;
    logic        rx_record;
    logic        rx_next;
    logic        freq_step_out;
    logic [5:0]  step_index;
    logic        busy;
    logic        sweep_done;

    fast_square_sweep_sched #(
        .DEF_RECORD (16'd5),
        .DEF_SETTLE (8'd3),
        .DEF_STEPS  (6'd4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .trigger       (trigger),
        .serial_strobe (serial_strobe),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .rx_reset      (rx_reset),
        .rx_record     (rx_record),
        .rx_next       (rx_next),
        .freq_step_out (freq_step_out),
        .step_index    (step_index),
        .busy          (busy),
        .sweep_done    (sweep_done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // vec bits: [5] rx_reset [4] record rise [3] record fall [2] rx_next [1] freq_step [0] sweep_done
    typedef struct {
        int         cyc;
        logic [5:0] vec;
        logic [5:0] step;
        logic       busy;
    } ev_t;

    typedef struct {
        int         cyc;
        logic       busy;
        logic       rec;
        logic [5:0] step;
    } pr_t;

    ev_t evq[$];
    pr_t prq[$];
    int  checks = 0;
    int  errors = 0;

    logic       rec_prev = 1'b0;
    logic [5:0] mon_vec;
    ev_t        mon_ev;
    pr_t        mon_pr;

    // Monitor: match strobe events and level probes against the queues
    always @(negedge clock) begin
        mon_vec  = {rx_reset, rx_record & ~rec_prev, ~rx_record & rec_prev,
                    rx_next, freq_step_out, sweep_done};
        rec_prev = rx_record;
        while (evq.size() > 0 && evq[0].cyc < cyc) begin
            mon_ev = evq.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event cyc %0d: got nothing, expected vec %b step %0d",
                     mon_ev.cyc, mon_ev.vec, mon_ev.step);
        end
        if (mon_vec != 6'b0) begin
            checks++;
            if (evq.size() == 0 || evq[0].cyc != cyc) begin
                errors++;
                $display("FAIL unexpected_event cyc %0d: got vec %b step %0d, expected none",
                         cyc, mon_vec, step_index);
            end else begin
                mon_ev = evq.pop_front();
                if (mon_ev.vec != mon_vec || mon_ev.step != step_index || mon_ev.busy != busy) begin
                    errors++;
                    $display("FAIL event cyc %0d: got vec %b step %0d busy %0b, expected vec %b step %0d busy %0b",
                             cyc, mon_vec, step_index, busy, mon_ev.vec, mon_ev.step, mon_ev.busy);
                end
            end
        end
        while (prq.size() > 0 && prq[0].cyc <= cyc) begin
            mon_pr = prq.pop_front();
            checks++;
            if (mon_pr.cyc != cyc || mon_pr.busy != busy || mon_pr.rec != rx_record
                || mon_pr.step != step_index) begin
                errors++;
                $display("FAIL probe cyc %0d (at %0d): got busy %0b rec %0b step %0d, expected busy %0b rec %0b step %0d",
                         mon_pr.cyc, cyc, busy, rx_record, step_index,
                         mon_pr.busy, mon_pr.rec, mon_pr.step);
            end
        end
    end

    task automatic push_ev(input int c, input logic [5:0] v, input int s, input logic b);
        ev_t e;
        e.cyc = c; e.vec = v; e.step = 6'(s); e.busy = b;
        evq.push_back(e);
    endtask

    task automatic push_probe(input int c, input logic b, input logic r, input int s);
        pr_t p;
        p.cyc = c; p.busy = b; p.rec = r; p.step = 6'(s);
        prq.push_back(p);
    endtask

    // Expected events of one sweep whose START is at cycle s; events at or after cut are dropped
    task automatic gen_sweep(input int s, input int steps, input int settle, input int record, input int cut);
        int st;
        int rc;
        int base;
        st = (settle == 0) ? 1 : settle;
        rc = (record == 0) ? 1 : record;
        if (s < cut) push_ev(s, 6'b100000, 0, 1'b1);
        for (int k = 0; k < steps; k++) begin
            base = s + 1 + k * (st + rc + 1);
            if (base + st < cut)
                push_ev(base + st, 6'b010000, k, 1'b1);
            if (base + st + rc < cut)
                push_ev(base + st + rc, (k == steps - 1) ? 6'b001111 : 6'b001110, k, 1'b1);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic cfg_write(input logic [31:0] d);
        serial_strobe = 1'b1;
        serial_addr   = 7'd80;
        serial_data   = d;
        @(negedge clock);
        serial_strobe = 1'b0;
        serial_addr   = 7'd0;
        serial_data   = 32'd0;
    endtask

    task automatic raise(output int s);
        trigger = 1'b1;
        s = cyc + 1;
    endtask

    int s;
    int s2;
    localparam int NOCUT = 1 << 30;

    initial begin
        reset         = 1'b1;
        trigger       = 1'b0;
        serial_strobe = 1'b0;
        serial_addr   = 7'd0;
        serial_data   = 32'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        push_probe(cyc + 1, 1'b0, 1'b0, 0);
        repeat (2) @(negedge clock);

        // Defaults: 4 steps, settle 3, record 5; record write mid-sweep is deferred
        raise(s);
        gen_sweep(s, 4, 3, 5, NOCUT);
        push_probe(s + 37, 1'b0, 1'b0, 0);
        wait_until(s + 5);
        cfg_write({1'b0, 1'b0, 6'd4, 8'd3, 16'd2});
        trigger = 1'b0;
        wait_until(s + 40);

        // Next sweep picks up record = 2
        raise(s);
        gen_sweep(s, 4, 3, 2, NOCUT);
        push_probe(s + 25, 1'b0, 1'b0, 0);
        @(negedge clock);
        trigger = 1'b0;
        wait_until(s + 28);

        // settle 0 / record 0 act as one tick each
        cfg_write({1'b0, 1'b0, 6'd3, 8'd0, 16'd0});
        raise(s);
        gen_sweep(s, 3, 0, 0, NOCUT);
        push_probe(s + 10, 1'b0, 1'b0, 0);
        @(negedge clock);
        trigger = 1'b0;
        wait_until(s + 13);

        // Continuous, 2 steps: back-to-back sweeps; mid-sweep rise ignored
        cfg_write({1'b1, 1'b0, 6'd2, 8'd1, 16'd1});
        raise(s);
        gen_sweep(s,      2, 1, 1, NOCUT);
        gen_sweep(s + 7,  2, 1, 1, NOCUT);
        gen_sweep(s + 14, 2, 1, 1, NOCUT);
        push_probe(s + 21, 1'b0, 1'b0, 0);
        wait_until(s + 2);
        trigger = 1'b0;
        wait_until(s + 3);
        trigger = 1'b1;
        wait_until(s + 9);
        cfg_write({1'b0, 1'b0, 6'd2, 8'd1, 16'd1});
        wait_until(s + 23);
        trigger = 1'b0;
        wait_until(s + 26);

        // Reset during RECORD of step 1 with trigger held high
        cfg_write({1'b0, 1'b0, 6'd4, 8'd3, 16'd5});
        raise(s);
        gen_sweep(s, 4, 3, 5, s + 15);
        push_ev(s + 15, 6'b001000, 0, 1'b0);
        push_probe(s + 20, 1'b0, 1'b0, 0);
        push_probe(s + 30, 1'b0, 1'b0, 0);
        wait_until(s + 14);
        reset = 1'b1;
        wait_until(s + 16);
        reset = 1'b0;
        wait_until(s + 31);
        trigger = 1'b0;
        wait_until(s + 33);
        raise(s2);
        gen_sweep(s2, 4, 3, 5, NOCUT);
        push_probe(s2 + 37, 1'b0, 1'b0, 0);
        @(negedge clock);
        trigger = 1'b0;
        wait_until(s2 + 40);

        // Shadow steps = 0: trigger rise does nothing
        cfg_write({1'b0, 1'b0, 6'd0, 8'd3, 16'd5});
        raise(s);
        push_probe(s,     1'b0, 1'b0, 0);
        push_probe(s + 1, 1'b0, 1'b0, 0);
        push_probe(s + 5, 1'b0, 1'b0, 0);
        wait_until(s + 3);
        trigger = 1'b0;
        wait_until(s + 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
